// File: rtl/button_sense.sv
// rtl/button_sense.sv - debounced push-button conditioner with short/long press classification
module button_sense #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8,
  parameter int HOLD_W      = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              button_n,
  input  logic              tick,
  input  logic [DB_W-1:0]   debounce,
  input  logic [HOLD_W-1:0] long_hold,
  output logic              pressed,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              short_press,
  output logic              long_press
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DB_PRESS,
    S_PRESSED,
    S_LONG,
    S_DB_RELEASE
  } state_t;

  state_t              state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                btn;
  logic [DB_W-1:0]     cnt, cnt_nx;
  logic [HOLD_W-1:0]   hold, hold_nx;
  logic                was_long, was_long_nx;
  logic                pressed_nx, press_nx, release_nx, short_nx, long_nx;

  // Synchronizer idles at 1 so reset reads as "released".
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
    end
  end

  assign btn = ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      hold          <= '0;
      was_long      <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      hold          <= hold_nx;
      was_long      <= was_long_nx;
      pressed       <= pressed_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      short_press   <= short_nx;
      long_press    <= long_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    hold_nx     = hold;
    was_long_nx = was_long;
    pressed_nx  = pressed;
    press_nx    = 1'b0;
    release_nx  = 1'b0;
    short_nx    = 1'b0;
    long_nx     = 1'b0;

    case (state)
      S_IDLE: begin
        pressed_nx = 1'b0;
        if (btn) begin
          state_nx = S_DB_PRESS;
          cnt_nx   = '0;
        end
      end

      S_DB_PRESS: begin
        if (!btn) begin
          state_nx = S_IDLE;
        end else if (cnt >= debounce) begin
          state_nx   = S_PRESSED;
          press_nx   = 1'b1;
          pressed_nx = 1'b1;
          hold_nx    = '0;
        end else if (tick) begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_PRESSED: begin
        // Hold keeps counting even on the cycle a release is seen.
        if (tick && (hold != '1)) begin
          hold_nx = hold + 1'b1;
        end
        if (!btn) begin
          state_nx    = S_DB_RELEASE;
          cnt_nx      = '0;
          was_long_nx = 1'b0;
        end else if ((long_hold != '0) && (hold >= long_hold)) begin
          state_nx = S_LONG;
          long_nx  = 1'b1;
        end
      end

      S_LONG: begin
        if (!btn) begin
          state_nx    = S_DB_RELEASE;
          cnt_nx      = '0;
          was_long_nx = 1'b1;
        end
      end

      S_DB_RELEASE: begin
        if (btn) begin
          state_nx = was_long ? S_LONG : S_PRESSED;
        end else if (cnt >= debounce) begin
          state_nx   = S_IDLE;
          pressed_nx = 1'b0;
          release_nx = 1'b1;
          short_nx   = ~was_long;
        end else if (tick) begin
          cnt_nx = cnt + 1'b1;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_sense.sv
// tb/tb_button_sense.sv - scoreboard bench for button_sense
module tb_button_sense;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        button_n;
  logic        tick;
  logic [7:0]  debounce;
  logic [15:0] long_hold;
  logic        pressed, press_pulse, release_pulse, short_press, long_press;

  localparam logic [3:0] EV_PRESS = 4'b1000;
  localparam logic [3:0] EV_REL   = 4'b0100;
  localparam logic [3:0] EV_SHORT = 4'b0010;
  localparam logic [3:0] EV_LONG  = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] ev;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  button_sense #(.SYNC_STAGES(2), .DB_W(8), .HOLD_W(16)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .button_n     (button_n),
    .tick         (tick),
    .debounce     (debounce),
    .long_hold    (long_hold),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] ev);
    exp_t x;
    x.cyc = c;
    x.ev  = ev;
    sbq.push_back(x);
  endtask

  task automatic monitor();
    exp_t       e;
    logic [3:0] obs;
    forever begin
      @(negedge clock);
      obs = {press_pulse, release_pulse, short_press, long_press};
      if (obs != 4'b0000) begin
        vectors++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc, obs);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || e.ev != obs) begin
            errors++;
            $display("FAIL event cyc=%0d got=%b required cyc=%0d ev=%b", cyc, obs, e.cyc, e.ev);
          end
        end
      end
    end
  endtask

  task automatic check_lvl(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive a tick on every edge whose number is a multiple of 8.
  task automatic tick_cycles(input int n);
    repeat (n) begin
      tick = ((cyc + 1) % 8 == 0);
      @(negedge clock);
    end
  endtask

  initial begin
    int b, r, p, q;
    rst_n     = 1'b0;
    button_n  = 1'b1;
    tick      = 1'b1;
    debounce  = 8'd3;
    long_hold = 16'd0;
    fork
      monitor();
    join_none

    wait_cyc(1);
    check_lvl("reset_pressed", pressed, 1'b0);
    check_lvl("reset_pulses", |{press_pulse, release_pulse, short_press, long_press}, 1'b0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3);

    // Short press, debounce 3
    b = cyc;
    button_n = 1'b0;
    push(b + 7, EV_PRESS);
    wait_cyc(6);
    check_lvl("t1_pressed_before", pressed, 1'b0);
    wait_cyc(1);
    check_lvl("t1_pressed_after", pressed, 1'b1);
    wait_cyc(93);
    check_lvl("t1_pressed_held", pressed, 1'b1);
    r = cyc;
    button_n = 1'b1;
    push(r + 7, EV_REL | EV_SHORT);
    wait_cyc(6);
    check_lvl("t1_pressed_rel_before", pressed, 1'b1);
    wait_cyc(1);
    check_lvl("t1_pressed_rel_after", pressed, 1'b0);
    wait_cyc(5);

    // Glitch shorter than the settle time
    debounce = 8'd5;
    button_n = 1'b0;
    wait_cyc(4);
    button_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_cyc(1);
      check_lvl("t2_glitch_pressed", pressed, 1'b0);
    end

    // Long press
    debounce  = 8'd2;
    long_hold = 16'd10;
    b = cyc;
    button_n = 1'b0;
    push(b + 6, EV_PRESS);
    push(b + 17, EV_LONG);
    wait_cyc(40);
    check_lvl("t3_pressed_long", pressed, 1'b1);
    r = cyc;
    button_n = 1'b1;
    push(r + 6, EV_REL);
    wait_cyc(10);

    // Release bounces during PRESSED shift the long event by one cycle each
    debounce  = 8'd4;
    long_hold = 16'd30;
    b = cyc;
    button_n = 1'b0;
    p = b + 8;
    push(p, EV_PRESS);
    push(p + 34, EV_LONG);
    wait_cyc(10);
    for (int k = 0; k < 3; k++) begin
      button_n = 1'b1;
      wait_cyc(1);
      button_n = 1'b0;
      for (int j = 0; j < 4; j++) begin
        check_lvl("t4_bounce_pressed", pressed, 1'b1);
        if (j < 3) wait_cyc(1);
      end
    end
    wait_cyc(30);
    r = cyc;
    button_n = 1'b1;
    push(r + 8, EV_REL);
    wait_cyc(12);

    // Tick gating: tick every 8 cycles
    debounce  = 8'd2;
    long_hold = 16'd0;
    tick      = 1'b0;
    while (cyc % 8 != 0) tick_cycles(1);
    b = cyc;
    button_n = 1'b0;
    push(b + 17, EV_PRESS);
    tick_cycles(16);
    check_lvl("t5_pressed_before", pressed, 1'b0);
    tick_cycles(1);
    check_lvl("t5_pressed_after", pressed, 1'b1);
    tick_cycles(23);
    r = cyc;
    button_n = 1'b1;
    push(r + 17, EV_REL | EV_SHORT);
    tick_cycles(20);
    tick = 1'b1;

    // Reset while in LONG
    debounce  = 8'd2;
    long_hold = 16'd5;
    b = cyc;
    button_n = 1'b0;
    push(b + 6, EV_PRESS);
    push(b + 12, EV_LONG);
    wait_cyc(14);
    check_lvl("t6_pressed_pre_reset", pressed, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_lvl("t6_reset_pressed", pressed, 1'b0);
    check_lvl("t6_reset_pulses", |{press_pulse, release_pulse, short_press, long_press}, 1'b0);
    long_hold = 16'd0;
    wait_cyc(2);
    rst_n = 1'b1;
    q = cyc;
    push(q + 6, EV_PRESS);
    wait_cyc(8);
    check_lvl("t6_repress_pressed", pressed, 1'b1);
    r = cyc;
    button_n = 1'b1;
    push(r + 6, EV_REL | EV_SHORT);
    wait_cyc(10);

    vectors++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d pending required=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/button_sense.md
# button_sense

Debounced front-panel push-button conditioner: the input-side counterpart of the LED stretch/indicator logic. It samples a raw, asynchronous, active-low button line. It debounces press and release against a programmable settle time and classifies each press as short or long. It emits one-cycle event pulses for the control/status logic that owns the panel.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer flip-flop depth on `button_n` (≥2).
- DB_W, 8, width of the debounce threshold and counter.
- HOLD_W, 16, width of the long-press threshold and hold counter.

Ports:
- clock  input  1  system clock; everything is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- button_n  input  1  raw button, low = pressed, asynchronous to `clock`.
- tick  input  1  one-cycle timebase strobe (e.g. 1 kHz); advances the debounce and hold counters.
- debounce  input  DB_W  settle time in ticks; quasi-static.
- long_hold  input  HOLD_W  long-press threshold in ticks; 0 disables long detection.
- pressed  output  1  debounced level, high while the button is considered down.
- press_pulse  output  1  one cycle when a press is accepted.
- release_pulse  output  1  one cycle when a release is accepted.
- short_press  output  1  one cycle at release, for presses that did not reach long.
- long_press  output  1  one cycle when hold time reaches `long_hold`.

## Operation
- Synchronizer: SYNC_STAGES flops, reset to 1 (released). `btn` is the inverted output of the last stage.
- Debounce counter `cnt` (DB_W) and hold counter `hold` (HOLD_W) both increment only on `tick`. `hold` saturates at all-ones.
- States:
  - IDLE: `pressed`=0. If `btn`, go to DB_PRESS and set `cnt`=0.
  - DB_PRESS: if !`btn`, return to IDLE (glitch rejected; no pulse). Otherwise, if `cnt` ≥ `debounce`, go to PRESSED, set `press_pulse`=1, `pressed`=1 and `hold`=0. Otherwise `cnt`++ on tick.
  - PRESSED: `hold`++ on tick. If !`btn`, go to DB_RELEASE with `cnt`=0 and `was_long`=0. This has priority over the long check in the same cycle. Otherwise, if `long_hold`≠0 and `hold` ≥ `long_hold`, go to LONG and set `long_press`=1.
  - LONG: if !`btn`, go to DB_RELEASE with `cnt`=0 and `was_long`=1.
  - DB_RELEASE: `pressed` stays 1 and `hold` is frozen. If `btn` (bounce), return to PRESSED or LONG according to `was_long`, keeping `hold`. Otherwise, if `cnt` ≥ `debounce`, go to IDLE, set `pressed`=0 and `release_pulse`=1, and set `short_press`=1 if !`was_long`. Otherwise `cnt`++ on tick.
- A threshold test and a tick in the same cycle: the transition wins and the counter value is irrelevant.
- All outputs are registered. Pulses are exactly one cycle and never overlap, except that `release_pulse` and `short_press` assert together.
- Exactly one of `short_press` or `long_press` fires per accepted press.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, synchronizer all 1, `cnt`=`hold`=`was_long`=0, all outputs 0.
- Reset mid-press: no release or short pulse is generated. After reset, a still-held button is re-accepted as a new press.
- Press latency, with `tick` tied high and `button_n` low before edge 1:
  - Synchronizer visible at edge SYNC_STAGES.
  - DB_PRESS at edge SYNC_STAGES+1.
  - `press_pulse` and `pressed` high after edge SYNC_STAGES+2+`debounce` (edge 4 for `debounce`=0 with the default depth).
- Release latency is symmetric: `release_pulse` rises SYNC_STAGES+2+`debounce` edges after `button_n` rises.
- Long: `long_press` fires on the edge after `hold` reaches `long_hold`, i.e. `long_hold`+1 cycles after `press_pulse` with `tick` tied high.
- With `tick` low forever and `debounce`>0, a press is never accepted.

## Test plan
- Reset, then `button_n` low for 100 cycles with `debounce`=3, `long_hold`=0, `tick`=1. Expect:
  - `press_pulse` exactly once at edge 7;
  - `pressed`=1 thereafter;
  - on release, `release_pulse` and `short_press` together, 7 edges after the rising edge.
- Glitch rejection: `debounce`=5, `tick`=1, `button_n` low for 4 cycles then high. Expect no pulses and `pressed` stays 0.
- Long press: `debounce`=2, `long_hold`=10, hold 40 cycles. Expect:
  - `long_press` once, 11 cycles after `press_pulse`;
  - on release, `release_pulse` with `short_press`=0.
- Release bounce: during PRESSED, toggle `button_n` high for 1 cycle at a time 3 times with `debounce`=4. Expect:
  - no `release_pulse`;
  - `pressed` steady at 1;
  - `hold` continues, so `long_press` timing is shifted only by the bounce cycles.
- Tick gating: `tick` every 8 cycles, `debounce`=2. Expect `press_pulse` only after 2 ticks are observed in DB_PRESS.
- Reset mid-press: assert `rst_n`=0 during LONG. Expect:
  - all outputs 0 immediately;
  - no `release_pulse`;
  - with the button still held after reset release, a fresh `press_pulse`.
